// File: rtl/prog_loader.sv
// prog_loader -- program image loader.
//
// Takes a byte stream (typically from a UART receiver) over a valid/ready
// handshake and assembles little-endian 32-bit words. It writes them one at
// a time into a word-addressed program RAM and holds the CPU in reset until
// the whole image has been written.
//
// Stream format:
//   4-byte word count (little-endian), then count*4 data bytes. Inside each
//   group of 4 bytes, the first byte lands in bits 7:0.
//
// Optional build macro PROG_LOADER_CHECKSUM_EN:
//   A running XOR is kept over every length and data byte. One extra byte
//   follows the image, including a zero-length image. The load ends in DONE
//   only if that byte matches the XOR; otherwise it ends in ERR.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   start_i      begins a load from IDLE, DONE or ERR (ignored while busy)
//   rx_data_i    stream byte
//   rx_valid_i   rx_data_i valid
//   rx_ready_o   loader can take a byte this cycle
//   mem_we_o     one-cycle write strobe per word
//   mem_addr_o   word address
//   mem_wdata_o  assembled word
//   busy_o       load in progress
//   done_o       image loaded
//   err_o        load aborted (oversize length or bad checksum)
//   cpu_rst_no   CPU reset, low holds the CPU in reset

module prog_loader #(
   parameter int MEM_DEPTH = 256,
   localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W+1:2] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              cpu_rst_no
);

   localparam logic [31:0] DEPTH = MEM_DEPTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   word_idx;
   logic [31:0]       len_q;
   // Only the three earlier bytes of a word need holding; the fourth byte
   // is merged straight from rx_data_i when the word completes.
   logic [23:0]       part_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              xfer;
   logic [31:0]       word_nxt;
   logic [ADDR_W:0]   idx_inc;
   logic              last_word;

   assign xfer      = rx_valid_i && rx_ready_o;
   assign word_nxt  = {rx_data_i, part_q};
   assign idx_inc   = word_idx + (ADDR_W+1)'(1);
   assign last_word = ({{(31-ADDR_W){1'b0}}, idx_inc} == len_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         byte_cnt    <= '0;
         word_idx    <= '0;
         len_q       <= '0;
         part_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
         rx_ready_o  <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         cpu_rst_no  <= 1'b0;
      end else begin
         case (state)
            // Idle and both terminal states wait for start; outputs were set
            // on the way in and simply hold here.
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  state      <= S_LEN;
                  byte_cnt   <= '0;
                  word_idx   <= '0;
                  part_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_q     <= '0;
`endif
                  rx_ready_o <= 1'b1;
                  busy_o     <= 1'b1;
                  done_o     <= 1'b0;
                  err_o      <= 1'b0;
                  cpu_rst_no <= 1'b0;
               end
            end

            S_LEN: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  part_q   <= word_nxt[31:8];
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_q   <= csum_q ^ rx_data_i;
`endif
                  if (byte_cnt == 2'd3) begin
                     len_q <= word_nxt;
                     if (word_nxt == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        // Empty image still carries a checksum byte.
                        state      <= S_CSUM;
`else
                        state      <= S_DONE;
                        rx_ready_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        cpu_rst_no <= 1'b1;
`endif
                     end else if (word_nxt > DEPTH) begin
                        state      <= S_ERR;
                        rx_ready_o <= 1'b0;
                        busy_o     <= 1'b0;
                        err_o      <= 1'b1;
                     end else begin
                        state    <= S_DATA;
                        word_idx <= '0;
                     end
                  end
               end
            end

            S_DATA: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  part_q   <= word_nxt[31:8];
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_q   <= csum_q ^ rx_data_i;
`endif
                  // Word complete: present the write next cycle and stall
                  // the stream for that one cycle.
                  if (byte_cnt == 2'd3) begin
                     state       <= S_WRITE;
                     rx_ready_o  <= 1'b0;
                     mem_we_o    <= 1'b1;
                     mem_addr_o  <= word_idx[ADDR_W-1:0];
                     mem_wdata_o <= word_nxt;
                  end
               end
            end

            S_WRITE: begin
               mem_we_o <= 1'b0;
               word_idx <= idx_inc;
               if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state      <= S_CSUM;
                  rx_ready_o <= 1'b1;
`else
                  state      <= S_DONE;
                  busy_o     <= 1'b0;
                  done_o     <= 1'b1;
                  cpu_rst_no <= 1'b1;
`endif
               end else begin
                  state      <= S_DATA;
                  rx_ready_o <= 1'b1;
               end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (xfer) begin
                  rx_ready_o <= 1'b0;
                  busy_o     <= 1'b0;
                  if (rx_data_i == csum_q) begin
                     state      <= S_DONE;
                     done_o     <= 1'b1;
                     cpu_rst_no <= 1'b1;
                  end else begin
                     state      <= S_ERR;
                     err_o      <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state      <= S_IDLE;
               rx_ready_o <= 1'b0;
               mem_we_o   <= 1'b0;
               busy_o     <= 1'b0;
               done_o     <= 1'b0;
               err_o      <= 1'b0;
               cpu_rst_no <= 1'b0;
            end
         endcase
      end
   end

endmodule
